// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_segment_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   // Brightness is expressed in eighths of a slot.
   localparam int DUTY_STEPS = 8;

endpackage

// File: rtl/seven_segment_slot_timer.sv
// Alternates BLANK (dead_cycles) and SHOW (slot_cycles) phases and flags the
// last cycle of each phase so the controller can act on the phase edges.
module seven_segment_slot_timer
   import seven_segment_pkg::*;
#(
   parameter int slot_cycles = 16,
   parameter int dead_cycles = 2,
   parameter int cnt_w       = 5
) (
   input  logic             clk,
   input  logic             rst,
   output scan_state_t      state,
   output logic [cnt_w-1:0] cnt,
   output logic             blank_end,
   output logic             show_end
);

   assign blank_end = (state == BLANK) && (cnt == cnt_w'(dead_cycles - 1));
   assign show_end  = (state == SHOW)  && (cnt == cnt_w'(slot_cycles - 1));

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BLANK;
         cnt   <= '0;
      end else if (blank_end) begin
         state <= SHOW;
         cnt   <= '0;
      end else if (show_end) begin
         state <= BLANK;
         cnt   <= '0;
      end else begin
         cnt   <= cnt + cnt_w'(1);
      end
   end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment driver: double-buffered frame data committed only at
// frame boundaries, per-digit enable mask and PWM brightness, all outputs registered.
module seven_segment_scan_controller
   import seven_segment_pkg::*;
#(
   parameter int clk_mhz     = 50,
   parameter int w_digit     = 8,
   parameter int slot_cycles = clk_mhz * 1000,
   parameter int dead_cycles = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [w_digit*8-1:0] load_segs,
   input  logic [w_digit-1:0]   load_en,
   input  logic [2:0]           brightness,
   output logic [7:0]           abcdefgh,
   output logic [w_digit-1:0]   digit,
   output logic                 frame_start
);

   localparam int CNT_W = $clog2((slot_cycles > dead_cycles ? slot_cycles : dead_cycles) + 1);
   localparam int IDX_W = (w_digit > 1) ? $clog2(w_digit) : 1;
   localparam int PW    = CNT_W + $clog2(DUTY_STEPS) + 1;

   scan_state_t          state;
   logic [CNT_W-1:0]     cnt;
   logic                 blank_end;
   logic                 show_end;

   logic [IDX_W-1:0]     idx;
   logic [w_digit*8-1:0] active_segs;
   logic [w_digit*8-1:0] pending_segs;
   logic [w_digit-1:0]   active_en;
   logic [w_digit-1:0]   pending_en;
   logic                 pending_full;
   logic [CNT_W-1:0]     on_cycles;

   logic                 boundary;
   logic                 commit;
   logic                 accept;
   logic [w_digit*8-1:0] show_segs;
   logic [w_digit-1:0]   show_en;
   logic [PW-1:0]        duty_prod;
   logic [CNT_W-1:0]     on_next;
   logic                 lit_next;
   logic [7:0]           seg_next;
   logic                 pending_full_next;

   seven_segment_slot_timer #(
      .slot_cycles (slot_cycles),
      .dead_cycles (dead_cycles),
      .cnt_w       (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .state     (state),
      .cnt       (cnt),
      .blank_end (blank_end),
      .show_end  (show_end)
   );

   assign boundary = blank_end && (idx == '0);
   assign commit   = boundary && pending_full;
   assign accept   = load_valid && load_ready;

   // Data being committed this edge must already drive the first SHOW cycle.
   assign show_segs = commit ? pending_segs : active_segs;
   assign show_en   = commit ? pending_en   : active_en;

   assign pending_full_next = accept || (pending_full && !commit);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      duty_prod = PW'(slot_cycles) * (PW'(brightness) + PW'(1));
      on_next   = CNT_W'(duty_prod >> $clog2(DUTY_STEPS));
      seg_next  = show_segs[8*idx +: 8];
      lit_next  = 1'b0;
      if (blank_end) begin
         lit_next = show_en[idx];
      end else if (state == SHOW && !show_end) begin
         lit_next = active_en[idx] && ((cnt + CNT_W'(1)) < on_cycles);
      end
   end

   // NOTE: the frame buffers are cleared on reset so a stale frame can never reappear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         active_segs  <= '0;
         pending_segs <= '0;
         active_en    <= '0;
         pending_en   <= '0;
         pending_full <= 1'b0;
         on_cycles    <= '0;
         load_ready   <= 1'b0;
         frame_start  <= 1'b0;
         digit        <= '0;
         abcdefgh     <= '0;
      end else begin
         if (show_end) begin
            idx <= (idx == IDX_W'(w_digit - 1)) ? '0 : idx + IDX_W'(1);
         end
         if (blank_end) begin
            on_cycles <= on_next;
         end
         if (commit) begin
            active_segs <= pending_segs;
            active_en   <= pending_en;
         end
         if (accept) begin
            pending_segs <= load_segs;
            pending_en   <= load_en;
         end
         pending_full <= pending_full_next;
         load_ready   <= !pending_full_next;
         frame_start  <= boundary;
         digit        <= lit_next ? (w_digit'(1) << idx) : '0;
         abcdefgh     <= lit_next ? seg_next : 8'h00;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: stimulus pushes one expected frame per load/brightness change,
// a monitor checks each frame cycle by cycle from its frame_start pulse.
module tb_seven_segment_scan_controller;

   localparam int NDIG   = 4;
   localparam int SLOT   = 16;
   localparam int DEAD   = 2;
   localparam int PERIOD = NDIG * (SLOT + DEAD);

   typedef struct {
      logic [31:0] segs;
      logic [3:0]  en;
      int          on;
   } frame_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [31:0] load_segs = '0;
   logic [3:0]  load_en = '0;
   logic [2:0]  brightness = 3'd7;
   logic [7:0]  abcdefgh;
   logic [3:0]  digit;
   logic        frame_start;

   int n_assert = 0;
   int n_fail   = 0;

   frame_t exp_q[$];
   frame_t cur;
   logic   measuring = 1'b0;
   int     t_frame, bad_cycles, first_bad, slot, pos;
   int     fs_count = 0;
   int     cyc_since_fs = 0;
   int     frames_checked = 0;
   logic [3:0] e_dig;
   logic [7:0] e_seg;
   int     fs0;

   seven_segment_scan_controller #(
      .clk_mhz     (50),
      .w_digit     (NDIG),
      .slot_cycles (SLOT),
      .dead_cycles (DEAD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .load_segs   (load_segs),
      .load_en     (load_en),
      .brightness  (brightness),
      .abcdefgh    (abcdefgh),
      .digit       (digit),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [31:0] segs, input logic [3:0] en, input int on);
      frame_t f;
      f.segs = segs;
      f.en   = en;
      f.on   = on;
      exp_q.push_back(f);
   endtask

   // Offer a frame and hold load_valid until the DUT takes it (bounded).
   task automatic do_load(input logic [31:0] segs, input logic [3:0] en);
      int waited = 0;
      @(negedge clk);
      load_valid = 1'b1;
      load_segs  = segs;
      load_en    = en;
      while (!load_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!load_ready) check("load_accept", load_ready, 1);
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic wait_checked(input int n);
      int guard = 0;
      while (frames_checked < n && guard < 400) begin
         @(posedge clk);
         guard++;
      end
      if (frames_checked < n) check("frames_checked", frames_checked, n);
   endtask

   // Monitor / scoreboard: one expected frame popped per observed frame_start.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            measuring = 1'b0;
         end else begin
            if (frame_start) begin
               fs_count++;
               cyc_since_fs = 0;
               if (measuring) begin
                  check("frame_period", t_frame, PERIOD);
                  check($sformatf("frame_content first_bad_t=%0d", first_bad), bad_cycles, 0);
                  frames_checked++;
               end
               if (exp_q.size() > 0) begin
                  cur        = exp_q.pop_front();
                  measuring  = 1'b1;
                  t_frame    = 0;
                  bad_cycles = 0;
                  first_bad  = -1;
               end else begin
                  measuring = 1'b0;
               end
            end else begin
               cyc_since_fs++;
            end
            if (measuring) begin
               slot  = t_frame / (SLOT + DEAD);
               pos   = t_frame % (SLOT + DEAD);
               e_dig = 4'b0000;
               e_seg = 8'h00;
               if (slot < NDIG && pos < SLOT && pos < cur.on && cur.en[slot]) begin
                  e_dig = 4'b0001 << slot;
                  e_seg = cur.segs[slot*8 +: 8];
               end
               if (digit !== e_dig || abcdefgh !== e_seg) begin
                  bad_cycles++;
                  if (first_bad < 0) first_bad = t_frame;
               end
               t_frame++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;

      // Reset state, then idle frames with no load: everything dark.
      repeat (3) @(negedge clk);
      check("reset_digit", digit, 0);
      check("reset_segs", abcdefgh, 0);
      check("reset_frame_start", frame_start, 0);
      check("reset_load_ready", load_ready, 0);
      push_frame(32'h0, 4'h0, 16);
      push_frame(32'h0, 4'h0, 16);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_reset", load_ready, 1);
      wait_checked(2);

      // Full brightness, all digits enabled.
      do_load(32'h80402010, 4'hF);
      push_frame(32'h80402010, 4'hF, 16);
      wait_checked(3);

      // Dimmed: 4 of 16, then 2 of 16 cycles lit.
      @(negedge clk);
      brightness = 3'd1;
      push_frame(32'h80402010, 4'hF, 4);
      wait_checked(4);
      @(negedge clk);
      brightness = 3'd0;
      push_frame(32'h80402010, 4'hF, 2);
      wait_checked(5);

      // Digits 1 and 3 disabled; frame period must not change.
      brightness = 3'd7;
      do_load(32'h80402010, 4'b0101);
      push_frame(32'h80402010, 4'b0101, 16);
      wait_checked(6);

      // Back-pressure: second offer waits for the boundary commit of the first.
      do_load(32'h0A0B0C0D, 4'hF);
      push_frame(32'h0A0B0C0D, 4'hF, 16);
      check("ready_low_when_full", load_ready, 0);
      fs0 = fs_count;
      do_load(32'h11223344, 4'b0111);
      check("boundary_before_accept", (fs_count > fs0), 1);
      push_frame(32'h11223344, 4'b0111, 16);
      wait_checked(8);

      // Fill pending, then reset in the middle of digit 2's SHOW slot.
      do_load(32'hFFFFFFFF, 4'hF);
      guard = 0;
      do begin
         @(negedge clk);
         #1;
         guard++;
      end while (cyc_since_fs != 41 && guard < 200);
      check("pre_reset_digit", digit, 4'b0100);
      check("pre_reset_segs", abcdefgh, 8'h22);
      #1 rst = 1'b1;
      #1;
      check("async_reset_digit", digit, 0);
      check("async_reset_segs", abcdefgh, 0);
      check("async_reset_ready", load_ready, 0);
      repeat (2) @(negedge clk);
      push_frame(32'h0, 4'h0, 16);
      push_frame(32'h0, 4'h0, 16);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_midrun_reset", load_ready, 1);
      wait_checked(10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_segment_scan_controller.md
SEVEN_SEGMENT_SCAN_CONTROLLER -- requirements
Module: seven_segment_scan_controller

Interface
REQ-001 SHALL have parameter clk_mhz, default 50: system clock frequency in MHz.
REQ-002 SHALL have parameter w_digit, default 8: number of multiplexed digits.
REQ-003 SHALL have parameter slot_cycles, default clk_mhz*1000: clock cycles each digit is shown, 1 kHz per digit at 50 MHz; minimum 8.
REQ-004 SHALL have parameter dead_cycles, default 4: all-off guard cycles between slots; minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port load_valid, input, 1 bit: a new frame is offered.
REQ-008 SHALL have port load_ready, output, 1 bit: the pending buffer is empty.
REQ-009 SHALL have port load_segs, input, w_digit*8 bits: abcdefgh (a = MSB) per digit; digit i is at [8i+7:8i].
REQ-010 SHALL have port load_en, input, w_digit bits: per-digit enable mask.
REQ-011 SHALL have port brightness, input, 3 bits: duty step; on-time is (brightness+1)/8 of the slot.
REQ-012 SHALL have port abcdefgh, output, 8 bits: segment bus, active-high.
REQ-013 SHALL have port digit, output, w_digit bits: digit strobe, one-hot or all zero.
REQ-014 SHALL have port frame_start, output, 1 bit: single-cycle pulse at the start of each frame.

Function
REQ-015 SHALL sequence the states BLANK (dead_cycles cycles) and SHOW (slot_cycles cycles), alternating, with the digit index advancing 0..w_digit-1 and wrapping to 0.
REQ-016 SHALL accept a load on the clock edge where load_valid and load_ready are both high, capturing load_segs and load_en into the pending buffer and marking it full.
REQ-017 SHALL hold load_ready low while the pending buffer is full.
REQ-018 SHALL commit pending data to the active buffer and mark pending empty on the BLANK->SHOW edge of index 0 (the frame boundary), so no frame ever shows mixed old and new data.
REQ-019 SHALL, when an accept and a frame boundary occur on the same edge, load the accepted data into pending and commit it at the next boundary; the active buffer SHALL be unaffected on that edge.
REQ-020 SHALL pulse frame_start high for exactly the first SHOW cycle of index 0; newly committed data SHALL be visible in that same cycle.
REQ-021 SHALL sample brightness on each BLANK->SHOW edge and set on_cycles = ((brightness+1)*slot_cycles)>>3, using a multiply wide enough not to overflow.
REQ-022 SHALL, in SHOW, drive digit[index] = 1 and abcdefgh = active segs[index] while slot_cnt < on_cycles and active en[index] = 1; otherwise digit = 0 and abcdefgh = 0.
REQ-023 SHALL drive digit = 0 and abcdefgh = 0 throughout BLANK.
REQ-024 SHALL give a disabled digit its full slot time, so frame period = w_digit*(slot_cycles+dead_cycles) regardless of load_en.
REQ-025 SHALL register all outputs; no output may depend combinationally on any input.

Reset
REQ-026 SHALL, while rst is high, immediately force: state BLANK; index 0; counters 0; active and pending buffers 0; pending empty; digit 0; abcdefgh 0; frame_start 0; load_ready 0.
REQ-027 SHALL raise load_ready in the first cycle after rst falls.
REQ-028 SHALL discard any pending or partially shown frame on a reset asserted mid-operation.

Structure
REQ-029 SHALL place the state enum typedef and the DUTY_STEPS = 8 constant in the shared package seven_segment_pkg.
REQ-030 SHALL implement slot/dead counting in one sub-module, seven_segment_slot_timer, which outputs end-of-BLANK and end-of-SHOW strobes.

Verification (w_digit=4, slot_cycles=16, dead_cycles=2)
REQ-031 SHALL verify: reset release, no load -> digit=0 and abcdefgh=0 continuously; frame_start every 72 cycles; load_ready=1.
REQ-032 SHALL verify: load segs=32'h80402010, en=4'hF, brightness=7 -> from the next frame_start, digit 0001/0010/0100/1000 each high 16 cycles, abcdefgh 10/20/40/80, 2-cycle gaps.
REQ-033 SHALL verify: brightness=1 -> each digit high 4 of 16 SHOW cycles; brightness=0 -> high 2 cycles.
REQ-034 SHALL verify: a second load while pending is full -> load_ready=0 and load_valid held; accepted only after the boundary commit; no mixed frame observed.
REQ-035 SHALL verify: en=4'b0101 -> digits 1 and 3 are dark but the frame period stays 72 cycles.
REQ-036 SHALL verify: rst asserted mid-SHOW of digit 2 -> outputs 0 in the same cycle; after release, old data is not redisplayed.
